// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// fifo_reader_pkg : state encoding and buffer-entry layout for the burst reader
// Revision 1.0
// ============================================================================
package fifo_reader_pkg;

   localparam int ENTRY_DATA_WIDTH = 32;

   typedef logic [1:0] rd_state_e;

   localparam rd_state_e IDLE  = 2'd0;
   localparam rd_state_e READ  = 2'd1;
   localparam rd_state_e DRAIN = 2'd2;
   localparam rd_state_e DONE  = 2'd3;

   typedef struct packed {
      logic [ENTRY_DATA_WIDTH-1:0] data;
      logic                        last;
   } buf_entry_t;

endpackage
`default_nettype wire

// File: rtl/stream_skid_buffer.sv
`default_nettype none
// ============================================================================
// stream_skid_buffer : 2-entry registered buffer decoupling a producer from a
// valid/ready sink. Revision 1.0
// ============================================================================
module stream_skid_buffer #(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_occ_lt2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             pop;
   logic             push;

   always_comb begin
      pop     = (count_q != 2'd0) & out_ready;
      // A full buffer only takes a new word when the head leaves in the same cycle.
      push    = in_valid & ((count_q != 2'd2) | pop);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      if (pop && (count_q == 2'd2)) begin
         head_d = tail_q;
      end
      if (push) begin
         if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
            head_d = in_data;
         end else begin
            tail_d = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign in_occ_lt2 = (count_q != 2'd2);
   assign out_valid  = (count_q != 2'd0);
   assign out_data   = head_q;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// fifo_burst_reader : pops a fixed-length burst from a show-ahead FIFO and
// replays it on a registered valid/ready stream. Revision 1.0
// ============================================================================
module fifo_burst_reader
   import fifo_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_q,
   output logic                  fifo_rdreq,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   typedef struct packed {
      rd_state_e            state;
      logic [LEN_WIDTH-1:0] remaining;
   } ctrl_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } entry_t;

   ctrl_t  ctrl_q, ctrl_d;
   entry_t push_entry;
   entry_t head_entry;
   logic   buf_lt2;

   // Pop is blocked during reset so a reset cycle never loses an extra FIFO word.
   assign fifo_rdreq = ~rst & (ctrl_q.state == READ) & ~fifo_empty
                     & (ctrl_q.remaining != '0) & buf_lt2;

   assign push_entry.data = fifo_q;
   assign push_entry.last = (ctrl_q.remaining == LEN_WIDTH'(1));

   always_comb begin
      ctrl_d = ctrl_q;
      case (ctrl_q.state)
         IDLE: begin
            if (start) begin
               ctrl_d.remaining = len;
               ctrl_d.state     = (len != '0) ? READ : DONE;
            end
         end
         READ: begin
            if (fifo_rdreq) begin
               ctrl_d.remaining = ctrl_q.remaining - LEN_WIDTH'(1);
               if (ctrl_q.remaining == LEN_WIDTH'(1)) begin
                  ctrl_d.state = DRAIN;
               end
            end else if (ctrl_q.remaining == '0) begin
               ctrl_d.state = DRAIN;
            end
         end
         DRAIN: begin
            // Leave on the edge that accepts the final beat, so done follows it directly.
            if (~m_valid | (m_valid & m_ready & m_last)) begin
               ctrl_d.state = DONE;
            end
         end
         DONE: begin
            ctrl_d.state = IDLE;
         end
         default: begin
            ctrl_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   stream_skid_buffer #(
      .WIDTH ($bits(entry_t))
   ) u_out_buf (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (fifo_rdreq),
      .in_data    (push_entry),
      .in_occ_lt2 (buf_lt2),
      .out_valid  (m_valid),
      .out_ready  (m_ready),
      .out_data   (head_entry)
   );

   assign m_data = head_entry.data;
   assign m_last = head_entry.last;
   assign busy   = (ctrl_q.state != IDLE);
   assign done   = (ctrl_q.state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// tb_fifo_burst_reader : directed scoreboard bench for fifo_burst_reader
// Revision 1.0
// ============================================================================
module tb_fifo_burst_reader;

   localparam int DW = 32;
   localparam int LW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          start   = 1'b0;
   logic [LW-1:0] len     = '0;
   logic          m_ready = 1'b0;
   logic          busy, done, fifo_empty, fifo_rdreq, m_valid, m_last;
   logic [DW-1:0] fifo_q, m_data;

   // Show-ahead FIFO model
   logic [DW-1:0] mem [0:63];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_q     = mem[rd_ptr[5:0]];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fifo_rdreq && !fifo_empty) rd_ptr <= rd_ptr + 1;
   end

   fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .fifo_empty (fifo_empty),
      .fifo_q     (fifo_q),
      .fifo_rdreq (fifo_rdreq),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last)
   );

   int vectors    = 0;
   int miscompares = 0;

   exp_t          exp_q[$];
   logic [DW-1:0] shadow[$];

   int cyc = 0, t0 = 0;
   int beats, first_beat, last_beat, valid_cnt, rd_cnt, rd_before_ready;
   int done_cnt, done_cyc, bad_pops;
   logic seen_ready;
   int feed_left = 0;
   logic [DW-1:0] feed_val = '0;
   logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_rst = 1'b1;
   logic [DW-1:0] prev_data = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic fifo_write(input logic [DW-1:0] w);
      mem[wr_ptr[5:0]] = w;
      wr_ptr++;
      shadow.push_back(w);
   endtask

   task automatic expect_from_shadow(input int n);
      logic [DW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = shadow.pop_front();
         exp_q.push_back({w, (i == n - 1)});
      end
   endtask

   task automatic clear_stats();
      beats = 0; first_beat = -1; last_beat = -1; valid_cnt = 0; rd_cnt = 0;
      rd_before_ready = -1; done_cnt = 0; done_cyc = -1; bad_pops = 0;
      seen_ready = 1'b0;
   endtask

   // One clock cycle: drive inputs at negedge, then sample the settled outputs.
   task automatic step(input logic rdy, input logic st, input logic [LW-1:0] ln, input logic rs);
      exp_t e;
      @(negedge clk);
      m_ready = rdy; start = st; len = ln; rst = rs;
      if (feed_left > 0 && (cyc % 3) == 0) begin
         mem[wr_ptr[5:0]] = feed_val;
         wr_ptr++;
         feed_val++;
         feed_left--;
      end
      #1;
      cyc++;
      if (prev_valid && !prev_ready && !prev_rst)
         chk("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, prev_last, prev_data}));
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(m_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(m_data), 64'(e.data));
            chk("beat_last", 64'(m_last), 64'(e.last));
            beats++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
         end
      end
      if (m_valid) valid_cnt++;
      if (rdy && !seen_ready) begin
         seen_ready      = 1'b1;
         rd_before_ready = rd_cnt;
      end
      if (fifo_rdreq) begin
         rd_cnt++;
         if (fifo_empty) bad_pops++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      prev_valid = m_valid; prev_ready = rdy; prev_data = m_data;
      prev_last  = m_last;  prev_rst   = rs;
   endtask

   task automatic run_burst(input int ln, input logic [31:0] pat, input int plen,
                            input int bound, input logic restart);
      clear_stats();
      step(1'b0, 1'b1, LW'(ln), 1'b0);
      t0 = cyc;
      chk("busy_at_start", 64'(busy), 64'd0);
      for (int i = 0; i < bound && done_cnt == 0; i++) begin
         step(pat[i % plen], restart && (i == 0), restart ? LW'(7) : LW'(0), 1'b0);
         if (i == 0) chk("busy_T1", 64'(busy), 64'd1);
      end
      chk("done_count", 64'(done_cnt), 64'd1);
      if (ln != 0) chk("done_after_last", 64'(done_cyc), 64'(last_beat + 1));
      else         chk("len0_done_T1", 64'(done_cyc), 64'(t0 + 1));
      step(1'b1, 1'b0, '0, 1'b0);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("done_single", 64'(done_cnt), 64'd1);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("no_empty_pop", 64'(bad_pops), 64'd0);
   endtask

   initial begin
      // Reset
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      chk("reset_outputs", 64'({busy, done, m_valid, m_last, fifo_rdreq, m_data}), 64'd0);
      step(1'b0, 1'b0, '0, 1'b0);
      chk("idle_outputs", 64'({busy, done, m_valid, m_last, fifo_rdreq, m_data}), 64'd0);

      // Back-to-back burst of 5 with sink always ready
      for (int i = 0; i < 5; i++) fifo_write(DW'(32'h10 + i));
      expect_from_shadow(5);
      run_burst(5, 32'hFFFF_FFFF, 32, 40, 1'b0);
      chk("t1_first_beat", 64'(first_beat), 64'(t0 + 2));
      chk("t1_last_beat", 64'(last_beat), 64'(t0 + 6));
      chk("t1_beats", 64'(beats), 64'd5);
      chk("t1_pops", 64'(rd_cnt), 64'd5);
      chk("t1_fifo_empty", 64'(fifo_empty), 64'd1);

      // FIFO starts empty, trickle-fed every third cycle
      for (int i = 0; i < 4; i++) exp_q.push_back({DW'(32'h40 + i), (i == 3)});
      feed_val  = DW'(32'h40);
      feed_left = 4;
      run_burst(4, 32'hFFFF_FFFF, 32, 60, 1'b0);
      chk("t3_beats", 64'(beats), 64'd4);
      chk("t3_pops", 64'(rd_cnt), 64'd4);

      // Full FIFO with a stalling sink
      for (int i = 0; i < 6; i++) fifo_write(DW'(32'h30 + i));
      expect_from_shadow(6);
      run_burst(6, 32'h0000_00B4, 8, 60, 1'b0);
      chk("t4_pops_before_ready", 64'(rd_before_ready), 64'd2);
      chk("t4_beats", 64'(beats), 64'd6);

      // Reset after three accepted beats of an 8-word burst
      for (int i = 0; i < 8; i++) fifo_write(DW'(32'h50 + i));
      for (int i = 0; i < 8; i++) exp_q.push_back({shadow[i], (i == 7)});
      clear_stats();
      step(1'b0, 1'b1, LW'(8), 1'b0);
      for (int i = 0; i < 20 && beats < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
      chk("t5_three_beats", 64'(beats), 64'd3);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);
      chk("t5_outputs_after_rst", 64'({busy, done, m_valid, m_last, fifo_rdreq, m_data}), 64'd0);
      exp_q.delete();
      // Three beats delivered plus one word lost in the output buffer
      for (int i = 0; i < 4; i++) void'(shadow.pop_front());
      chk("t5_fifo_left", 64'(wr_ptr - rd_ptr), 64'(shadow.size()));
      expect_from_shadow(2);
      run_burst(2, 32'hFFFF_FFFF, 32, 20, 1'b0);
      chk("t5_restart_beats", 64'(beats), 64'd2);

      // start pulsed during READ with a different len must be ignored
      for (int i = 0; i < 5; i++) fifo_write(DW'(32'h60 + i));
      expect_from_shadow(3);
      run_burst(3, 32'hFFFF_FFFF, 32, 30, 1'b1);
      chk("t6_beats", 64'(beats), 64'd3);
      chk("t6_fifo_left", 64'(wr_ptr - rd_ptr), 64'(shadow.size()));

      // Zero-length burst with words waiting in the FIFO
      run_burst(0, 32'hFFFF_FFFF, 32, 10, 1'b0);
      chk("len0_no_pop", 64'(rd_cnt), 64'd0);
      chk("len0_no_valid", 64'(valid_cnt), 64'd0);
      chk("len0_fifo_untouched", 64'(wr_ptr - rd_ptr), 64'(shadow.size()));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
